// File: rtl/threshold_fifo.sv
// threshold_fifo: synchronous FIFO with programmable almost-empty/almost-full
// flags, registered read data and a sticky overflow/underflow error flag.
module threshold_fifo #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned FIFO_WORD_SIZE = 10,
  parameter int unsigned FIFO_PTR_SIZE  = $clog2(FIFO_DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [FIFO_WORD_SIZE-1:0] data_in,
  input  logic                      pop,
  input  logic [FIFO_PTR_SIZE-1:0]  almost_empty_threshold,
  input  logic [FIFO_PTR_SIZE-1:0]  almost_full_threshold,
  output logic [FIFO_WORD_SIZE-1:0] data_out,
  output logic                      valid_out,
  output logic [FIFO_PTR_SIZE:0]    count,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_empty,
  output logic                      almost_full,
  output logic                      error
);

  localparam int unsigned CNT_W = FIFO_PTR_SIZE + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  logic [FIFO_WORD_SIZE-1:0] mem [FIFO_DEPTH];
  logic [FIFO_PTR_SIZE-1:0]  wr_ptr;
  logic [FIFO_PTR_SIZE-1:0]  rd_ptr;
  logic                      push_accept;
  logic                      pop_accept;

  // Occupancy flags decoded from registered count and the live thresholds
  always_comb begin
    empty        = (count == '0);
    full         = (count == DEPTH_CNT);
    almost_empty = (count <= {1'b0, almost_empty_threshold});
    almost_full  = ((DEPTH_CNT - count) <= {1'b0, almost_full_threshold});
  end

  // A push on a full FIFO is still taken when a pop frees the slot this cycle
  always_comb begin
    pop_accept  = pop && !empty;
    push_accept = push && (!full || pop_accept);
  end

  // Storage array; contents are intentionally not cleared by reset
  always_ff @(posedge clk) begin
    if (!reset && push_accept) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers and occupancy counter
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_accept) begin
        wr_ptr <= wr_ptr + FIFO_PTR_SIZE'(1);
      end
      if (pop_accept) begin
        rd_ptr <= rd_ptr + FIFO_PTR_SIZE'(1);
      end
      case ({push_accept, pop_accept})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered read port; data_out holds its value between pops
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= pop_accept;
      if (pop_accept) begin
        data_out <= mem[rd_ptr];
      end
    end
  end

  // Sticky error on any rejected push or pop, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      error <= 1'b0;
    end else if ((push && !push_accept) || (pop && !pop_accept)) begin
      error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_threshold_fifo.sv
// tb_threshold_fifo: table-driven directed bench for threshold_fifo plus
// hand-written sequences for wrap-around, full-throughput and live thresholds.
module tb_threshold_fifo;

  logic       clk;
  logic       reset;
  logic       push;
  logic [9:0] data_in;
  logic       pop;
  logic [2:0] ae_thr;
  logic [2:0] af_thr;
  logic [9:0] data_out;
  logic       valid_out;
  logic [3:0] count;
  logic       empty;
  logic       full;
  logic       almost_empty;
  logic       almost_full;
  logic       error;

  int n_chk  = 0;
  int n_fail = 0;

  threshold_fifo dut (
    .clk                    (clk),
    .reset                  (reset),
    .push                   (push),
    .data_in                (data_in),
    .pop                    (pop),
    .almost_empty_threshold (ae_thr),
    .almost_full_threshold  (af_thr),
    .data_out               (data_out),
    .valid_out              (valid_out),
    .count                  (count),
    .empty                  (empty),
    .full                   (full),
    .almost_empty           (almost_empty),
    .almost_full            (almost_full),
    .error                  (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       psh;
    logic       pp;
    logic [9:0] din;
    logic [2:0] ae;
    logic [2:0] af;
    logic [3:0] x_cnt;
    logic       x_e;
    logic       x_f;
    logic       x_ae;
    logic       x_af;
    logic       x_v;
    logic [9:0] x_d;
    logic       x_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] c, input logic e, input logic f,
                         input logic ae, input logic af, input logic v, input logic [9:0] d,
                         input logic err);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".empty"}, 32'(empty), 32'(e));
    chk({tag, ".full"}, 32'(full), 32'(f));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(ae));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(af));
    chk({tag, ".valid_out"}, 32'(valid_out), 32'(v));
    chk({tag, ".data_out"}, 32'(data_out), 32'(d));
    chk({tag, ".error"}, 32'(error), 32'(err));
  endtask

  task automatic step(input logic r, input logic pu, input logic po, input logic [9:0] d);
    reset   = r;
    push    = pu;
    pop     = po;
    data_in = d;
    @(posedge clk);
    #1;
    reset = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
  endtask

  task automatic add(input logic r, input logic pu, input logic po, input logic [9:0] d,
                     input logic [2:0] ae, input logic [2:0] af, input logic [3:0] c,
                     input logic e, input logic f, input logic xae, input logic xaf,
                     input logic v, input logic [9:0] xd, input logic err);
    vec_t t;
    t = '{r, pu, po, d, ae, af, c, e, f, xae, xaf, v, xd, err};
    vecs.push_back(t);
  endtask

  initial begin
    logic [9:0] model[$];
    logic [9:0] w;
    logic [9:0] exp_w;

    reset = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0; ae_thr = 3'd2; af_thr = 3'd2;

    // Reset with push/pop asserted for two cycles
    add(1,1,1,10'h155, 2,2, 0,1,0,1,0,0,10'h000,0);
    add(1,1,1,10'h155, 2,2, 0,1,0,1,0,0,10'h000,0);
    // Fill 0x001..0x008, AE=2 AF=2
    add(0,1,0,10'h001, 2,2, 1,0,0,1,0,0,10'h000,0);
    add(0,1,0,10'h002, 2,2, 2,0,0,1,0,0,10'h000,0);
    add(0,1,0,10'h003, 2,2, 3,0,0,0,0,0,10'h000,0);
    add(0,1,0,10'h004, 2,2, 4,0,0,0,0,0,10'h000,0);
    add(0,1,0,10'h005, 2,2, 5,0,0,0,0,0,10'h000,0);
    add(0,1,0,10'h006, 2,2, 6,0,0,0,1,0,10'h000,0);
    add(0,1,0,10'h007, 2,2, 7,0,0,0,1,0,10'h000,0);
    add(0,1,0,10'h008, 2,2, 8,0,1,0,1,0,10'h000,0);
    // Overflow push of 0x3FF is dropped, error sets
    add(0,1,0,10'h3FF, 2,2, 8,0,1,0,1,0,10'h000,1);
    // Drain 8 words in order; error stays sticky
    add(0,0,1,10'h000, 2,2, 7,0,0,0,1,1,10'h001,1);
    add(0,0,1,10'h000, 2,2, 6,0,0,0,1,1,10'h002,1);
    add(0,0,1,10'h000, 2,2, 5,0,0,0,0,1,10'h003,1);
    add(0,0,1,10'h000, 2,2, 4,0,0,0,0,1,10'h004,1);
    add(0,0,1,10'h000, 2,2, 3,0,0,0,0,1,10'h005,1);
    add(0,0,1,10'h000, 2,2, 2,0,0,1,0,1,10'h006,1);
    add(0,0,1,10'h000, 2,2, 1,0,0,1,0,1,10'h007,1);
    add(0,0,1,10'h000, 2,2, 0,1,0,1,0,1,10'h008,1);
    // Idle: data_out holds, valid_out drops
    add(0,0,0,10'h000, 2,2, 0,1,0,1,0,0,10'h008,1);
    // Reset, then underflow pop
    add(1,0,0,10'h000, 2,2, 0,1,0,1,0,0,10'h000,0);
    add(0,0,1,10'h000, 2,2, 0,1,0,1,0,0,10'h000,1);
    // Reset, then push+pop on empty: write taken, pop rejected
    add(1,0,0,10'h000, 2,2, 0,1,0,1,0,0,10'h000,0);
    add(0,1,1,10'h0AA, 2,2, 1,0,0,1,0,0,10'h000,1);
    add(0,0,1,10'h000, 2,2, 0,1,0,1,0,1,10'h0AA,1);
    // Threshold 0: almost flags collapse onto empty/full
    add(1,0,0,10'h000, 0,0, 0,1,0,1,0,0,10'h000,0);

    foreach (vecs[i]) begin
      ae_thr = vecs[i].ae;
      af_thr = vecs[i].af;
      step(vecs[i].rst, vecs[i].psh, vecs[i].pp, vecs[i].din);
      chk_all($sformatf("vec%0d", i), vecs[i].x_cnt, vecs[i].x_e, vecs[i].x_f,
              vecs[i].x_ae, vecs[i].x_af, vecs[i].x_v, vecs[i].x_d, vecs[i].x_err);
    end

    // Wrap-around: 8 rounds of push 5 / pop 5 (40 words)
    ae_thr = 3'd2; af_thr = 3'd2;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 5; k++) begin
        w = 10'(10'h200 + r * 5 + k);
        model.push_back(w);
        step(0, 1, 0, w);
      end
      chk($sformatf("wrap%0d.count_full5", r), 32'(count), 32'd5);
      for (int k = 0; k < 5; k++) begin
        step(0, 0, 1, '0);
        exp_w = model.pop_front();
        chk($sformatf("wrap%0d.data%0d", r, k), 32'(data_out), 32'(exp_w));
        chk($sformatf("wrap%0d.valid%0d", r, k), 32'(valid_out), 32'd1);
      end
    end
    chk("wrap.count_end", 32'(count), 32'd0);
    chk("wrap.error_end", 32'(error), 32'd0);

    // Simultaneous push+pop at full, with AF=0 so almost_full tracks full
    af_thr = 3'd0;
    for (int k = 0; k < 8; k++) begin
      w = 10'(10'h100 + k);
      model.push_back(w);
      step(0, 1, 0, w);
      if (k == 6) chk("af0.at7", 32'(almost_full), 32'd0);
    end
    chk("af0.at8", 32'(almost_full), 32'd1);
    model.push_back(10'h1AA);
    step(0, 1, 1, 10'h1AA);
    exp_w = model.pop_front();
    chk("pp_full.count", 32'(count), 32'd8);
    chk("pp_full.data", 32'(data_out), 32'(exp_w));
    chk("pp_full.valid", 32'(valid_out), 32'd1);
    chk("pp_full.error", 32'(error), 32'd0);
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 1, '0);
      exp_w = model.pop_front();
      chk($sformatf("pp_full.drain%0d", k), 32'(data_out), 32'(exp_w));
    end
    chk("pp_full.empty_end", 32'(empty), 32'd1);

    // Live threshold change and mid-operation reset
    step(0, 0, 1, '0);
    chk("live.err_set", 32'(error), 32'd1);
    ae_thr = 3'd3;
    for (int k = 0; k < 4; k++) step(0, 1, 0, 10'(10'h011 + k));
    chk("live.count4", 32'(count), 32'd4);
    chk("live.ae_at3", 32'(almost_empty), 32'd0);
    ae_thr = 3'd5;
    #1;
    chk("live.ae_at5", 32'(almost_empty), 32'd1);
    step(1, 0, 1, '0);
    chk("midrst.count", 32'(count), 32'd0);
    chk("midrst.error", 32'(error), 32'd0);
    chk("midrst.valid", 32'(valid_out), 32'd0);
    step(0, 0, 1, '0);
    chk("midrst.underflow", 32'(error), 32'd1);
    chk("midrst.no_valid", 32'(valid_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
